// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, reset PC, opcode/funct encodings,
// instruction class codes and small helpers used by the front end.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int INSTR_SIZE = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct3 encodings
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_LOAD    = 4'd1,
        CLS_STORE   = 4'd2,
        CLS_BRANCH  = 4'd3,
        CLS_JUMP    = 4'd4,
        CLS_UPPER   = 4'd5,
        CLS_FENCE   = 4'd6,
        CLS_SYSTEM  = 4'd7,
        CLS_ILLEGAL = 4'd15
    } instr_class_e;

    // One prefetch entry: address and the word fetched from it
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INSTR_SIZE-1:0] instr;
    } fetch_pkt_t;

    // Sequential next address, plain 32-bit wrap
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Coarse instruction class from the major opcode
    function automatic instr_class_e classify(input logic [6:0] opc);
        instr_class_e cls;
        case (opc)
            OPC_OP, OPC_OP_IMM:    cls = CLS_ALU;
            OPC_LOAD:              cls = CLS_LOAD;
            OPC_STORE:             cls = CLS_STORE;
            OPC_BRANCH:            cls = CLS_BRANCH;
            OPC_JAL, OPC_JALR:     cls = CLS_JUMP;
            OPC_LUI, OPC_AUIPC:    cls = CLS_UPPER;
            OPC_MISC_MEM:          cls = CLS_FENCE;
            OPC_SYSTEM:            cls = CLS_SYSTEM;
            default:               cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Synchronous FIFO with flush. Read/write pointers carry one extra MSB so
// full and empty are distinguished without a separate counter.
module rv32i_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Storage write; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; flush returns both pointers to the origin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch front end: issues word reads, buffers in-order
// responses in a prefetch FIFO, and flushes/drops stale data on redirect.
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        err_rsp
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   rsp_pc_nxt;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt_nxt;
    logic          err_rsp_nxt;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [63:0]   fifo_dout;
    fetch_pkt_t    fifo_head;
    fetch_pkt_t    push_pkt;

    logic [CW:0]   credit_used;
    logic [31:0]   redirect_aligned;
    logic          accept;
    logic          rsp_ok;
    logic          push;
    logic          pop;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};

    // Request is combinational so a redirect can withdraw it in the same cycle;
    // rst masks it so every output reads zero while reset is held.
    assign imem_req_valid = !rst && fetch_en && !redirect_valid &&
                            (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept = imem_req_valid && imem_req_ready;
    // A response with nothing in flight is spurious and must not touch state
    assign rsp_ok = imem_rsp_valid && (outstanding != '0);
    // Credits make full impossible at push; the full term is a belt-and-braces guard
    assign push   = rsp_ok && !redirect_valid && (drop_cnt == '0) && !fifo_full;
    assign pop    = instr_valid && instr_ready && !redirect_valid;

    assign push_pkt  = '{pc: rsp_pc, instr: imem_rsp_data};
    assign fifo_head = fetch_pkt_t'(fifo_dout);

    rv32i_sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_pkt),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head is masked while empty so decode never sees stale storage
    assign instr_valid = !fifo_empty;
    assign instr_data  = fifo_empty ? 32'h0000_0000 : fifo_head.instr;
    assign instr_pc    = fifo_empty ? 32'h0000_0000 : fifo_head.pc;

    // Next-state for PCs, in-flight/drop counters and the sticky error
    always_comb begin
        fetch_pc_nxt    = fetch_pc;
        rsp_pc_nxt      = rsp_pc;
        drop_cnt_nxt    = drop_cnt;
        outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_ok);
        err_rsp_nxt     = err_rsp || (imem_rsp_valid && (outstanding == '0));

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream
            fetch_pc_nxt = redirect_aligned;
            rsp_pc_nxt   = redirect_aligned;
            drop_cnt_nxt = outstanding - CW'(rsp_ok);
        end else begin
            if (accept) begin
                fetch_pc_nxt = pc_plus4(fetch_pc);
            end else begin
                fetch_pc_nxt = fetch_pc;
            end
            if (push) begin
                rsp_pc_nxt = pc_plus4(rsp_pc);
            end else begin
                rsp_pc_nxt = rsp_pc;
            end
            if (rsp_ok && (drop_cnt != '0)) begin
                drop_cnt_nxt = drop_cnt - CW'(1);
            end else begin
                drop_cnt_nxt = drop_cnt;
            end
        end
    end

    // Fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            err_rsp     <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            rsp_pc      <= rsp_pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
            err_rsp     <= err_rsp_nxt;
        end
    end

endmodule
